// File: rtl/wishbone_stream_master.sv
// rtl/wishbone_stream_master.sv - Wishbone classic initiator driving stream-bridge status/data queues
// Each request polls its stream's status word, then moves one data word and returns one response.
module wishbone_stream_master #(
  parameter logic [31:0] p_base_addr   = 32'h3000_0000,
  parameter int          p_num_istream = 2,
  parameter int          p_num_ostream = 2,
  parameter int          p_idx_nbits   = 2,
  parameter int          p_max_polls   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_idx_nbits-1:0] req_idx,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  output logic [31:0]            wbm_dat_o,
  input  logic                   wbm_ack_i,
  input  logic [31:0]            wbm_dat_i
);

  localparam int                    c_cnt_nbits    = (p_max_polls > 1) ? $clog2(p_max_polls) : 1;
  localparam logic [c_cnt_nbits-1:0] c_last_poll   = c_cnt_nbits'(p_max_polls - 1);
  localparam logic [31:0]           c_num_istream  = 32'(p_num_istream);
  localparam logic [31:0]           c_num_ostream  = 32'(p_num_ostream);
  localparam logic [31:0]           c_ostream_base = p_base_addr + c_num_istream * 32'd8;

  typedef enum logic [1:0] {IDLE, POLL, XFER, RESP} state_t;

  state_t                   state, state_next;
  logic                     op_r, op_next;
  logic [p_idx_nbits-1:0]   idx_r, idx_next;
  logic [31:0]              data_r, data_next;
  logic [c_cnt_nbits-1:0]   poll_cnt, poll_cnt_next;
  logic [31:0]              resp_data_r, resp_data_next;
  logic                     resp_err_r, resp_err_next;

  logic [31:0] req_idx_ext;
  logic        req_idx_bad;
  logic [31:0] status_adr;

  // Index check uses 32-bit arithmetic so stream counts above 2**p_idx_nbits still compare correctly.
  assign req_idx_ext = 32'(req_idx);
  assign req_idx_bad = req_op ? (req_idx_ext >= c_num_ostream) : (req_idx_ext >= c_num_istream);
  assign status_adr  = (op_r ? c_ostream_base : p_base_addr) + 32'(idx_r) * 32'd8;

  assign resp_data = resp_data_r;
  assign resp_err  = resp_err_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      idx_r       <= '0;
      data_r      <= 32'h0;
      poll_cnt    <= '0;
      resp_data_r <= 32'h0;
      resp_err_r  <= 1'b0;
    end else begin
      state       <= state_next;
      op_r        <= op_next;
      idx_r       <= idx_next;
      data_r      <= data_next;
      poll_cnt    <= poll_cnt_next;
      resp_data_r <= resp_data_next;
      resp_err_r  <= resp_err_next;
    end
  end

  // Outputs depend on registered state only; bus lines are quiet outside POLL/XFER.
  always_comb begin
    state_next     = state;
    op_next        = op_r;
    idx_next       = idx_r;
    data_next      = data_r;
    poll_cnt_next  = poll_cnt;
    resp_data_next = resp_data_r;
    resp_err_next  = resp_err_r;
    req_rdy        = 1'b0;
    resp_val       = 1'b0;
    wbm_cyc_o      = 1'b0;
    wbm_stb_o      = 1'b0;
    wbm_we_o       = 1'b0;
    wbm_sel_o      = 4'h0;
    wbm_adr_o      = 32'h0;
    wbm_dat_o      = 32'h0;

    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          op_next       = req_op;
          idx_next      = req_idx;
          data_next     = req_data;
          poll_cnt_next = '0;
          if (req_idx_bad) begin
            resp_data_next = 32'h0;
            resp_err_next  = 1'b1;
            state_next     = RESP;
          end else begin
            state_next = POLL;
          end
        end
      end

      POLL: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = status_adr;
        if (wbm_ack_i) begin
          if (wbm_dat_i[0]) begin
            state_next = XFER;
          end else if (poll_cnt == c_last_poll) begin
            resp_data_next = 32'h0;
            resp_err_next  = 1'b1;
            state_next     = RESP;
          end else begin
            poll_cnt_next = poll_cnt + 1'b1;
          end
        end
      end

      XFER: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_we_o  = ~op_r;
        wbm_adr_o = status_adr + 32'd4;
        wbm_dat_o = op_r ? 32'h0 : data_r;
        if (wbm_ack_i) begin
          resp_data_next = op_r ? wbm_dat_i : 32'h0;
          resp_err_next  = 1'b0;
          state_next     = RESP;
        end
      end

      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_stream_master.sv
// tb/tb_wishbone_stream_master.sv - scoreboard bench for wishbone_stream_master
`timescale 1ns/1ps
module tb_wishbone_stream_master;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NI = 2, NO = 2, IDXB = 2, MAXP = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_val, req_rdy, req_op;
  logic [IDXB-1:0] req_idx;
  logic [31:0]     req_data;
  logic            resp_val, resp_rdy, resp_err;
  logic [31:0]     resp_data;
  logic            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]      wbm_sel_o;
  logic [31:0]     wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 clk = ~clk;

  wishbone_stream_master #(
    .p_base_addr(BASE), .p_num_istream(NI), .p_num_ostream(NO),
    .p_idx_nbits(IDXB), .p_max_polls(MAXP)
  ) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_idx(req_idx), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; } bus_t;
  typedef struct { logic [31:0] data; logic err; int lat; } resp_t;

  bus_t        exp_bus[$];
  resp_t       exp_resp[$];
  logic [31:0] status_q[$];
  logic [31:0] rd_word = 32'h0;
  int          wait_states = 0;
  int          stb_age = 0;
  int          bus_count = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic bus_t mk_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    mk_bus.adr = a; mk_bus.we = w; mk_bus.dat = d;
  endfunction

  function automatic resp_t mk_resp(input logic [31:0] d, input logic e, input int l);
    mk_resp.data = d; mk_resp.err = e; mk_resp.lat = l;
  endfunction

  // Slave model: acks after wait_states cycles of strobe; bus transfers checked against the scoreboard.
  always @(negedge clk) begin : slave
    bus_t e;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    if (reset || !(wbm_cyc_o && wbm_stb_o)) begin
      stb_age = 0;
    end else if (stb_age < wait_states) begin
      stb_age++;
    end else begin
      stb_age = 0;
      wbm_ack_i = 1'b1;
      bus_count++;
      if (wbm_adr_o[2] == 1'b0) begin
        if (status_q.size() > 0) wbm_dat_i = status_q.pop_front();
      end else if (!wbm_we_o) begin
        wbm_dat_i = rd_word;
      end
      checks++;
      if (exp_bus.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected: got adr=%h we=%b dat=%h, required no transfer", wbm_adr_o, wbm_we_o, wbm_dat_o);
      end else begin
        e = exp_bus.pop_front();
        if (wbm_adr_o !== e.adr || wbm_we_o !== e.we || wbm_dat_o !== e.dat || wbm_sel_o !== 4'hF) begin
          failures++;
          $display("FAIL bus_xfer: got adr=%h we=%b dat=%h sel=%h, required adr=%h we=%b dat=%h sel=f",
                   wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, e.adr, e.we, e.dat);
        end
      end
    end
  end

  task automatic send_req(input logic op, input logic [IDXB-1:0] idx, input logic [31:0] data);
    int n = 0;
    req_val = 1'b1; req_op = op; req_idx = idx; req_data = data;
    while (!req_rdy && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  // Called in the cycle after acceptance; lat is the cycle number (accept = 0) of resp_val.
  task automatic collect_resp(output logic got, output logic [31:0] d, output logic e, output int lat);
    int n = 0;
    while (!resp_val && n < 200) begin @(posedge clk); #1; n++; end
    got = resp_val; d = resp_data; e = resp_err; lat = n + 1;
    if (got) begin
      resp_rdy = 1'b1; @(posedge clk); #1; resp_rdy = 1'b0;
    end
  endtask

  task automatic run_req(input logic op, input logic [IDXB-1:0] idx, input logic [31:0] data,
                         output logic got, output logic [31:0] d, output logic e, output int lat, output int nbus);
    int b0 = bus_count;
    send_req(op, idx, data);
    collect_resp(got, d, e, lat);
    nbus = bus_count - b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_rdy !== 1'b1) begin failures++; $display("FAIL reset_req_rdy: got %b required 1", req_rdy); end
    checks++; if (resp_val !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
      failures++; $display("FAIL reset_resp: got val=%b data=%h err=%b required 0/0/0", resp_val, resp_data, resp_err); end
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0) begin
      failures++; $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%h required all 0", wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_rdy !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: got rdy=%b cyc=%b required 1/0", req_rdy, wbm_cyc_o); end
  endtask

  task automatic test_write_basic();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    status_q.push_back(32'h1);
    exp_bus.push_back(mk_bus(32'h3000_0000, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0004, 1'b1, 32'h1234_5678));
    exp_resp.push_back(mk_resp(32'h0, 1'b0, 3));
    run_req(1'b0, 2'd0, 32'h1234_5678, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL write_resp_seen: got %b required 1", got); end
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL write_resp: got data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    checks++; if (lat !== x.lat) begin failures++; $display("FAIL write_latency: got %0d required %0d", lat, x.lat); end
    checks++; if (nbus !== 2) begin failures++; $display("FAIL write_bus_count: got %0d required 2", nbus); end
  endtask

  task automatic test_read_polls();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    rd_word = 32'hDEAD_BEEF;
    status_q.push_back(32'h0); status_q.push_back(32'h0); status_q.push_back(32'h0); status_q.push_back(32'h1);
    for (int i = 0; i < 4; i++) exp_bus.push_back(mk_bus(32'h3000_0018, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_001C, 1'b0, 32'h0));
    exp_resp.push_back(mk_resp(32'hDEAD_BEEF, 1'b0, 6));
    run_req(1'b1, 2'd1, 32'hFFFF_FFFF, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL read_resp: got data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    checks++; if (lat !== x.lat) begin failures++; $display("FAIL read_latency: got %0d required %0d", lat, x.lat); end
    checks++; if (nbus !== 5) begin failures++; $display("FAIL read_bus_count: got %0d required 5", nbus); end
  endtask

  task automatic test_poll_timeout();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    for (int i = 0; i < MAXP; i++) exp_bus.push_back(mk_bus(32'h3000_0008, 1'b0, 32'h0));
    exp_resp.push_back(mk_resp(32'h0, 1'b1, 5));
    run_req(1'b0, 2'd1, 32'h5555_AAAA, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err) begin failures++; $display("FAIL timeout_resp: got data=%h err=%b required %h/%b", d, e, x.data, x.err); end
    checks++; if (lat !== x.lat) begin failures++; $display("FAIL timeout_latency: got %0d required %0d", lat, x.lat); end
    checks++; if (nbus !== MAXP) begin failures++; $display("FAIL timeout_poll_count: got %0d required %0d", nbus, MAXP); end
  endtask

  task automatic test_bad_index();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    logic       ops[3]  = '{1'b0, 1'b1, 1'b1};
    logic [1:0] idxs[3] = '{2'd2, 2'd3, 2'd2};
    rd_word = 32'h7654_3210;
    for (int i = 0; i < 3; i++) begin
      exp_resp.push_back(mk_resp(32'h0, 1'b1, 1));
      run_req(ops[i], idxs[i], 32'hABCD_0000 + 32'(i), got, d, e, lat, nbus);
      x = exp_resp.pop_front();
      checks++; if (d !== x.data || e !== x.err || lat !== x.lat) begin
        failures++; $display("FAIL bad_idx_resp[%0d]: got data=%h err=%b lat=%0d required %h/%b/%0d", i, d, e, lat, x.data, x.err, x.lat); end
      checks++; if (nbus !== 0) begin failures++; $display("FAIL bad_idx_bus[%0d]: got %0d transfers required 0", i, nbus); end
    end
  endtask

  task automatic test_wait_states();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    wait_states = 2;
    status_q.push_back(32'h1);
    exp_bus.push_back(mk_bus(32'h3000_0008, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_000C, 1'b1, 32'h0BAD_F00D));
    exp_resp.push_back(mk_resp(32'h0, 1'b0, 7));
    run_req(1'b0, 2'd1, 32'h0BAD_F00D, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err || lat !== x.lat) begin
      failures++; $display("FAIL wait_write: got data=%h err=%b lat=%0d required %h/%b/%0d", d, e, lat, x.data, x.err, x.lat); end
    wait_states = 1;
    rd_word = 32'h8000_0001;
    status_q.push_back(32'h0); status_q.push_back(32'h1);
    exp_bus.push_back(mk_bus(32'h3000_0010, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0010, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0014, 1'b0, 32'h0));
    exp_resp.push_back(mk_resp(32'h8000_0001, 1'b0, 7));
    run_req(1'b1, 2'd0, 32'h0, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err || lat !== x.lat) begin
      failures++; $display("FAIL wait_read: got data=%h err=%b lat=%0d required %h/%b/%0d", d, e, lat, x.data, x.err, x.lat); end
    wait_states = 0;
  endtask

  task automatic test_back_to_back();
    logic got, e; logic [31:0] d, d0; logic e0; int lat, n; resp_t x;
    rd_word = 32'hCAFE_0001;
    status_q.push_back(32'h1); status_q.push_back(32'h1);
    exp_bus.push_back(mk_bus(32'h3000_0010, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0014, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0008, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_000C, 1'b1, 32'hA5A5_5A5A));
    exp_resp.push_back(mk_resp(32'hCAFE_0001, 1'b0, 3));
    exp_resp.push_back(mk_resp(32'h0, 1'b0, 3));
    send_req(1'b1, 2'd0, 32'h0);
    n = 0;
    while (!resp_val && n < 50) begin @(posedge clk); #1; n++; end
    d0 = resp_data; e0 = resp_err;
    x = exp_resp.pop_front();
    checks++; if (resp_val !== 1'b1 || d0 !== x.data || e0 !== x.err) begin
      failures++; $display("FAIL bp_first_resp: got val=%b data=%h err=%b required 1/%h/%b", resp_val, d0, e0, x.data, x.err); end
    req_val = 1'b1; req_op = 1'b0; req_idx = 2'd1; req_data = 32'hA5A5_5A5A;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_val !== 1'b1 || resp_data !== d0 || resp_err !== e0 || req_rdy !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]: got val=%b data=%h err=%b rdy=%b required 1/%h/%b/0", i, resp_val, resp_data, resp_err, req_rdy, d0, e0); end
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    checks++; if (resp_val !== 1'b0 || req_rdy !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      failures++; $display("FAIL bp_drain_idle: got val=%b rdy=%b cyc=%b required 0/1/0", resp_val, req_rdy, wbm_cyc_o); end
    @(posedge clk); #1;
    req_val = 1'b0;
    checks++; if (req_rdy !== 1'b0 || wbm_cyc_o !== 1'b1) begin
      failures++; $display("FAIL bp_second_accept: got rdy=%b cyc=%b required 0/1", req_rdy, wbm_cyc_o); end
    collect_resp(got, d, e, lat);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err || lat !== x.lat) begin
      failures++; $display("FAIL bp_second_resp: got data=%h err=%b lat=%0d required %h/%b/%0d", d, e, lat, x.data, x.err, x.lat); end
  endtask

  task automatic test_reset_mid_poll();
    logic got, e; logic [31:0] d; int lat, nbus; resp_t x;
    wait_states = 100;
    send_req(1'b0, 2'd0, 32'h1111_2222);
    @(posedge clk); #1;
    checks++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) begin
      failures++; $display("FAIL rst_in_poll: got cyc=%b stb=%b required 1/1", wbm_cyc_o, wbm_stb_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || resp_val !== 1'b0) begin
      failures++; $display("FAIL rst_abandon: got cyc=%b stb=%b val=%b required 0/0/0", wbm_cyc_o, wbm_stb_o, resp_val); end
    @(posedge clk); #1;
    reset = 1'b0;
    wait_states = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_rdy !== 1'b1 || resp_val !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      failures++; $display("FAIL rst_recover_idle: got rdy=%b val=%b cyc=%b required 1/0/0", req_rdy, resp_val, wbm_cyc_o); end
    status_q.push_back(32'h1);
    exp_bus.push_back(mk_bus(32'h3000_0000, 1'b0, 32'h0));
    exp_bus.push_back(mk_bus(32'h3000_0004, 1'b1, 32'h3333_4444));
    exp_resp.push_back(mk_resp(32'h0, 1'b0, 3));
    run_req(1'b0, 2'd0, 32'h3333_4444, got, d, e, lat, nbus);
    x = exp_resp.pop_front();
    checks++; if (d !== x.data || e !== x.err || lat !== x.lat || nbus !== 2) begin
      failures++; $display("FAIL rst_after_write: got data=%h err=%b lat=%0d nbus=%0d required %h/%b/%0d/2", d, e, lat, nbus, x.data, x.err, x.lat); end
  endtask

  initial begin
    req_val = 1'b0; req_op = 1'b0; req_idx = '0; req_data = 32'h0; resp_rdy = 1'b0;
    test_reset();
    test_write_basic();
    test_read_polls();
    test_poll_timeout();
    test_bad_index();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_poll();
    checks++; if (exp_bus.size() != 0 || exp_resp.size() != 0 || status_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got bus=%0d resp=%0d status=%0d left required 0/0/0", exp_bus.size(), exp_resp.size(), status_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
